// File: rtl/prt_fald_pkg.sv
// Shared FALD definitions: readout FSM states, the nibble-bus record common
// with the control block, and the LED buffer status record.
package prt_fald_pkg;

  localparam int C_NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_OUT  = 2'd3
  } lpb_state_e;

  typedef struct packed {
    logic [C_NIB_W-1:0] dat;
    logic               vld;
  } lpb_struct;

  // Everything a checker needs to follow the buffer's control state.
  typedef struct packed {
    lpb_state_e state;
    logic       pend;
    logic       wbank;
    logic       err;
  } lpb_stat_t;

  function automatic int nib_per_word(input int bpc);
    return bpc / C_NIB_W;
  endfunction

endpackage

// File: rtl/prt_fald_lpb_ram.sv
// Simple dual-port RAM for the LED pixel buffer: one write port and one
// registered read port, address = {bank, index}.
module prt_fald_lpb_ram #(
  parameter string P_VENDOR = "none",
  parameter int    P_AW     = 9,
  parameter int    P_DW     = 12
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [P_AW-1:0] i_waddr,
  input  logic [P_DW-1:0] i_wdata,
  input  logic            i_re,
  input  logic [P_AW-1:0] i_raddr,
  output logic [P_DW-1:0] o_rdata
);

  generate
    if (P_VENDOR == "xilinx") begin : g_xil
      (* ram_style = "block" *) logic [P_DW-1:0] r_mem [2**P_AW];
      logic [P_DW-1:0] r_rdata;

      always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
      end

      assign o_rdata = r_rdata;
    end else begin : g_inf
      logic [P_DW-1:0] r_mem [2**P_AW];
      logic [P_DW-1:0] r_rdata;

      always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
      end

      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/prt_fald_lpb.sv
// FALD LED pixel buffer: packs control-block nibbles into LED words in a
// double-buffered RAM and streams the committed frame to the LED driver.
module prt_fald_lpb
  import prt_fald_pkg::*;
#(
  parameter string P_VENDOR = "none",
  parameter int    P_LEDS   = 256,
  parameter int    P_BPC    = 12
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic [3:0]       LPB_DAT_IN,
  input  logic             LPB_VLD_IN,
  input  logic             UPD_IN,
  output logic [P_BPC-1:0] LED_DAT_OUT,
  output logic             LED_VLD_OUT,
  input  logic             LED_RDY_IN,
  output logic             LED_SOF_OUT,
  output logic             LED_EOF_OUT,
  output logic             BSY_OUT,
  output logic             ERR_OUT
);

  localparam int N  = nib_per_word(P_BPC);
  localparam int LW = $clog2(P_LEDS);
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  lpb_struct        w_lpb;
  lpb_stat_t        w_stat;
  logic [NW-1:0]    r_ncnt;
  logic [P_BPC-1:0] r_acc;
  logic [P_BPC-1:0] w_word;
  logic [LW:0]      r_wptr;
  logic             r_wbank;
  logic             r_pend;
  logic             r_err;
  logic             w_nib_ok;
  logic             w_word_done;
  logic             w_full;
  logic             w_we;
  logic             w_err_set;
  logic             w_swap;
  logic             w_rbank;

  lpb_state_e       r_state;
  lpb_state_e       w_state_nxt;
  logic [LW-1:0]    r_rptr;
  logic [P_BPC-1:0] r_dat;
  logic             r_sof;
  logic             r_eof;
  logic             w_rd_en;
  logic             w_cap;
  logic             w_vld;
  logic             w_xfer;
  logic [P_BPC-1:0] w_ram_rdata;

  assign w_lpb  = '{dat: LPB_DAT_IN, vld: LPB_VLD_IN};
  assign w_stat = '{state: r_state, pend: r_pend, wbank: r_wbank, err: r_err};

  // ---------------- write side: nibble packing ----------------
  always_comb begin
    w_word = r_acc;
    for (int k = 0; k < N; k++) begin
      if (r_ncnt == NW'(k)) w_word[k*C_NIB_W +: C_NIB_W] = w_lpb.dat;
    end
  end

  // A pending update freezes the write bank until the swap happens.
  assign w_nib_ok    = w_lpb.vld && !r_pend;
  assign w_word_done = w_nib_ok && (r_ncnt == NW'(N - 1));
  assign w_full      = (r_wptr == (LW+1)'(P_LEDS));
  assign w_we        = w_word_done && !w_full;
  assign w_err_set   = (w_word_done && w_full) || (w_lpb.vld && r_pend);
  assign w_swap      = r_pend && (r_state == ST_IDLE);
  assign w_rbank     = ~w_stat.wbank;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_ncnt  <= '0;
      r_acc   <= '0;
      r_wptr  <= '0;
      r_wbank <= 1'b0;
      r_pend  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (UPD_IN) begin
        r_ncnt <= '0;
        r_acc  <= '0;
        r_wptr <= '0;
      end else if (w_nib_ok) begin
        if (w_word_done) begin
          r_ncnt <= '0;
          r_acc  <= '0;
        end else begin
          r_ncnt <= r_ncnt + 1'b1;
          r_acc  <= w_word;
        end
        if (w_we) r_wptr <= r_wptr + 1'b1;
      end

      if (w_swap) r_wbank <= ~r_wbank;

      if (UPD_IN)      r_pend <= 1'b1;
      else if (w_swap) r_pend <= 1'b0;

      // The update starts a fresh frame, so its clear outranks this cycle's error.
      if (UPD_IN)         r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  prt_fald_lpb_ram #(
    .P_VENDOR (P_VENDOR),
    .P_AW     (LW + 1),
    .P_DW     (P_BPC)
  ) u_ram (
    .i_clk   (CLK_IN),
    .i_we    (w_we),
    .i_waddr ({r_wbank, r_wptr[LW-1:0]}),
    .i_wdata (w_word),
    .i_re    (w_rd_en),
    .i_raddr ({w_rbank, r_rptr}),
    .o_rdata (w_ram_rdata)
  );

  // ---------------- readout FSM ----------------
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_swap) w_state_nxt = ST_RD;
      ST_RD:   w_state_nxt = ST_CAP;
      ST_CAP:  w_state_nxt = ST_OUT;
      ST_OUT:  if (LED_RDY_IN) w_state_nxt = r_eof ? ST_IDLE : ST_RD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake: LED_VLD_OUT rises only in OUT and, together with data and
  // SOF/EOF, holds until a cycle where LED_RDY_IN is also high; that cycle
  // is the transfer.
  always_comb begin
    w_rd_en = (r_state == ST_RD);
    w_cap   = (r_state == ST_CAP);
    w_vld   = (r_state == ST_OUT);
    w_xfer  = w_vld && LED_RDY_IN;
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      r_rptr <= '0;
      r_dat  <= '0;
      r_sof  <= 1'b0;
      r_eof  <= 1'b0;
    end else begin
      if (w_cap) begin
        r_dat <= w_ram_rdata;
        r_sof <= (r_rptr == '0);
        r_eof <= (r_rptr == LW'(P_LEDS - 1));
      end
      if (w_xfer) r_rptr <= r_eof ? '0 : r_rptr + 1'b1;
    end
  end

  assign LED_DAT_OUT = r_dat;
  assign LED_VLD_OUT = w_vld;
  assign LED_SOF_OUT = r_sof;
  assign LED_EOF_OUT = r_eof;
  assign BSY_OUT     = (w_stat.state != ST_IDLE) || w_stat.pend;
  assign ERR_OUT     = w_stat.err;

endmodule

// File: tb/tb_prt_fald_lpb.sv
// Directed bench for the FALD LED pixel buffer with a 4-zone, 12-bit frame.
module tb_prt_fald_lpb;

  localparam int LEDS = 4;
  localparam int BPC  = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     nib;
  logic           nvld;
  logic           upd;
  logic [BPC-1:0] led_dat;
  logic           led_vld;
  logic           rdy;
  logic           sof;
  logic           eof;
  logic           bsy;
  logic           err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [13:0] exp_q[$];
  int          xfer_cyc[$];
  int          bsy_low;

  prt_fald_lpb #(
    .P_VENDOR ("none"),
    .P_LEDS   (LEDS),
    .P_BPC    (BPC)
  ) dut (
    .CLK_IN      (clk),
    .RST_IN      (rst),
    .LPB_DAT_IN  (nib),
    .LPB_VLD_IN  (nvld),
    .UPD_IN      (upd),
    .LED_DAT_OUT (led_dat),
    .LED_VLD_OUT (led_vld),
    .LED_RDY_IN  (rdy),
    .LED_SOF_OUT (sof),
    .LED_EOF_OUT (eof),
    .BSY_OUT     (bsy),
    .ERR_OUT     (err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] d);
    nib  = d;
    nvld = 1'b1;
    pos();
    nvld = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w);
    for (int i = 0; i < 3; i++) send_nib(w[i*4 +: 4]);
  endtask

  task automatic send_upd();
    upd = 1'b1;
    pos();
    upd = 1'b0;
  endtask

  task automatic push_frame(input logic [11:0] w0, input logic [11:0] w1,
                            input logic [11:0] w2, input logic [11:0] w3);
    exp_q.push_back({2'b10, w0});
    exp_q.push_back({2'b00, w1});
    exp_q.push_back({2'b00, w2});
    exp_q.push_back({2'b01, w3});
  endtask

  task automatic wait_vld(input string tag);
    int c = 0;
    while (!led_vld && c < 20) begin
      pos();
      c++;
    end
    check(tag, 32'(led_vld), 32'd1);
  endtask

  // Accepts nwords transfers against exp_q; optional stall on one word and
  // optional first-valid latency (cycles after the call starts).
  task automatic drain(input int nwords, input int stall_word, input int stall_len,
                       input int exp_lat);
    int          got = 0;
    int          cyc = 0;
    int          stall_left = stall_len;
    int          first = -1;
    logic        stall_now;
    logic [13:0] o;
    logic [13:0] e;
    bsy_low = 0;
    xfer_cyc.delete();
    while (got < nwords && cyc < 300) begin
      stall_now = (stall_left > 0) && (got == stall_word) && led_vld;
      rdy = !stall_now;
      if (stall_now) stall_left--;
      @(negedge clk);
      if (!bsy) bsy_low++;
      if (led_vld && first < 0) first = cyc;
      o = {sof, eof, led_dat};
      if (stall_now) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '1;
        check("hold_vld", 32'(led_vld), 32'd1);
        check("hold_word", 32'(o), 32'(e));
      end else if (led_vld) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check($sformatf("word%0d", got), 32'(o), 32'(e));
        xfer_cyc.push_back(cyc);
        got++;
      end
      pos();
      cyc++;
    end
    rdy = 1'b0;
    check("drain_cnt", 32'(got), 32'(nwords));
    if (exp_lat >= 0) check("first_vld_lat", 32'(first), 32'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    nib  = '0;
    nvld = 1'b0;
    upd  = 1'b0;
    rdy  = 1'b0;
    repeat (2) pos();
    @(negedge clk);
    check("rst_vld", 32'(led_vld), 32'd0);
    check("rst_sof", 32'(sof), 32'd0);
    check("rst_eof", 32'(eof), 32'd0);
    check("rst_dat", 32'(led_dat), 32'd0);
    check("rst_bsy", 32'(bsy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    pos();
    rst = 1'b0;
    pos();

    // Single frame, nibbles 1..C, first valid four cycles after the update.
    for (int i = 1; i <= 12; i++) send_nib(4'(i));
    send_upd();
    push_frame(12'h321, 12'h654, 12'h987, 12'hCBA);
    drain(4, -1, 0, 3);
    @(negedge clk);
    check("t1_bsy_done", 32'(bsy), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    pos();

    // Backpressure: ten stalled cycles on the second word.
    send_word(12'hA5F);
    send_word(12'h012);
    send_word(12'h7E3);
    send_word(12'hB4C);
    send_upd();
    push_frame(12'hA5F, 12'h012, 12'h7E3, 12'hB4C);
    drain(4, 1, 10, -1);

    // Deferred update: frame B committed while frame A is still streaming.
    send_word(12'h1F0);
    send_word(12'h2E1);
    send_word(12'h3D2);
    send_word(12'h4C3);
    send_upd();
    pos();
    send_word(12'h5B4);
    send_word(12'h6A5);
    send_word(12'h796);
    send_word(12'h887);
    send_upd();
    send_nib(4'h5);
    @(negedge clk);
    check("t3_err_pend_nib", 32'(err), 32'd1);
    check("t3_bsy_pend", 32'(bsy), 32'd1);
    pos();
    push_frame(12'h1F0, 12'h2E1, 12'h3D2, 12'h4C3);
    push_frame(12'h5B4, 12'h6A5, 12'h796, 12'h887);
    drain(8, -1, 0, -1);
    if (xfer_cyc.size() >= 5) begin
      check("t3_gap_norm", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
      check("t3_gap_defer", 32'(xfer_cyc[4] - xfer_cyc[3]), 32'd4);
    end else begin
      check("t3_xfers", 32'(xfer_cyc.size()), 32'd5);
    end
    check("t3_bsy_low", 32'(bsy_low), 32'd0);

    // Empty update clears ERR and replays the stale bank (frame A).
    send_upd();
    @(negedge clk);
    check("t4_err_clr", 32'(err), 32'd0);
    pos();
    push_frame(12'h1F0, 12'h2E1, 12'h3D2, 12'h4C3);
    drain(4, -1, 0, -1);

    // Overflow: fifth word dropped, ERR set, next update clears it.
    send_word(12'h111);
    send_word(12'h222);
    send_word(12'h333);
    send_word(12'h444);
    @(negedge clk);
    check("t4_err_full", 32'(err), 32'd0);
    pos();
    send_word(12'h555);
    @(negedge clk);
    check("t4_err_ovf", 32'(err), 32'd1);
    pos();
    send_upd();
    @(negedge clk);
    check("t4_err_upd", 32'(err), 32'd0);
    pos();
    push_frame(12'h111, 12'h222, 12'h333, 12'h444);
    drain(4, -1, 0, -1);

    // Partial word discarded by update; the frame read back is stale A.
    send_nib(4'hE);
    send_nib(4'hF);
    send_upd();
    push_frame(12'h1F0, 12'h2E1, 12'h3D2, 12'h4C3);
    drain(4, -1, 0, -1);

    // Packing restarts at [3:0]; a word completing with UPD_IN is committed.
    send_nib(4'h1);
    send_nib(4'h2);
    nib  = 4'h3;
    nvld = 1'b1;
    upd  = 1'b1;
    pos();
    nvld = 1'b0;
    upd  = 1'b0;
    push_frame(12'h321, 12'h222, 12'h333, 12'h444);
    drain(4, -1, 0, 3);

    // Reset while the second word is presented.
    send_upd();
    exp_q.push_back({2'b10, 12'h1F0});
    drain(1, -1, 0, -1);
    wait_vld("t6_vld_word1");
    rst = 1'b1;
    pos();
    @(negedge clk);
    check("t6_rst_vld", 32'(led_vld), 32'd0);
    check("t6_rst_bsy", 32'(bsy), 32'd0);
    pos();
    rst = 1'b0;
    pos();
    send_upd();
    push_frame(12'h1F0, 12'h2E1, 12'h3D2, 12'h4C3);
    drain(4, -1, 0, 3);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
